// File: rtl/wm_cycle_ctrl.sv
// Washing-machine cycle sequencer: fill/wash/drain/rinse/spin with timeouts.
// Define WM_EXTRA_RINSE_EN for a second drain/fill/rinse pass before spin.
module wm_cycle_ctrl #(
  parameter int TICK_DIV  = 1000,
  parameter int WASH_T    = 12,
  parameter int RINSE_T   = 6,
  parameter int SPIN_T    = 8,
  parameter int FILL_TMO  = 20,
  parameter int DRAIN_TMO = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       door_closed,
  input  logic       level_full,
  input  logic       level_empty,
  output logic [2:0] stage,
  output logic       valve_in,
  output logic       pump_out,
  output logic       motor_on,
  output logic       motor_fast,
  output logic       door_lock,
  output logic       busy,
  output logic       done,
  output logic       fault
);

  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    FILL1 = 3'b001,
    WASH  = 3'b010,
    DRAIN = 3'b011,
    FILL2 = 3'b100,
    RINSE = 3'b101,
    SPIN  = 3'b110,
    ENDS  = 3'b111
  } state_t;

  localparam int M1   = (WASH_T > RINSE_T) ? WASH_T : RINSE_T;
  localparam int M2   = (M1 > SPIN_T) ? M1 : SPIN_T;
  localparam int M3   = (M2 > FILL_TMO) ? M2 : FILL_TMO;
  localparam int TMAX = (M3 > DRAIN_TMO) ? M3 : DRAIN_TMO;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  state_t          state, state_n;
  logic            flt, flt_n;
  logic [PW-1:0]   presc;
  logic [TW-1:0]   timer;
  logic            run, tick, go_flt;
  logic            wash_end, rinse_end, spin_end;
  logic            fill_tmo, drain_tmo;

`ifdef WM_EXTRA_RINSE_EN
  logic            pass;
`endif

  assign run  = (state != IDLE) && (state != ENDS);
  assign tick = run && !pause && (presc == PW'(TICK_DIV - 1));

  // Each duration ends on the tick that would carry timer to T.
  assign wash_end  = tick && (timer == TW'(WASH_T - 1));
  assign rinse_end = tick && (timer == TW'(RINSE_T - 1));
  assign spin_end  = tick && (timer == TW'(SPIN_T - 1));
  assign fill_tmo  = tick && (timer == TW'(FILL_TMO - 1));
  assign drain_tmo = tick && (timer == TW'(DRAIN_TMO - 1));

  always_comb begin
    state_n = state;
    flt_n   = flt;
    go_flt  = 1'b0;
    if (!run) begin
      if (!flt && start && door_closed) state_n = FILL1;
    end else if (!door_closed) begin
      go_flt = 1'b1;
    end else if (!pause) begin
      unique case (state)
        FILL1: begin
          if (level_full)    state_n = WASH;
          else if (fill_tmo) go_flt  = 1'b1;
        end
        WASH: if (wash_end) state_n = DRAIN;
        DRAIN: begin
          if (level_empty)    state_n = FILL2;
          else if (drain_tmo) go_flt  = 1'b1;
        end
        FILL2: begin
          if (level_full)    state_n = RINSE;
          else if (fill_tmo) go_flt  = 1'b1;
        end
        RINSE: begin
`ifdef WM_EXTRA_RINSE_EN
          if (rinse_end) state_n = pass ? SPIN : DRAIN;
`else
          if (rinse_end) state_n = SPIN;
`endif
        end
        SPIN: if (spin_end) state_n = ENDS;
        default: ;
      endcase
    end
    if (go_flt) begin
      state_n = ENDS;
      flt_n   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      flt   <= 1'b0;
      presc <= '0;
      timer <= '0;
    end else begin
      state <= state_n;
      flt   <= flt_n;
      if (state_n != state || !run) begin
        presc <= '0;
        timer <= '0;
      end else if (!pause) begin
        if (tick) begin
          presc <= '0;
          timer <= timer + 1'b1;
        end else begin
          presc <= presc + 1'b1;
        end
      end
    end
  end

`ifdef WM_EXTRA_RINSE_EN
  always_ff @(posedge clk) begin
    if (reset)
      pass <= 1'b0;
    else if (state_n == FILL1 && state != FILL1)
      pass <= 1'b0;
    else if (state == RINSE && state_n == DRAIN)
      pass <= 1'b1;
  end
`endif

  assign stage      = state;
  assign valve_in   = !pause && (state == FILL1 || state == FILL2);
  assign pump_out   = !pause && (state == DRAIN || state == SPIN);
  assign motor_on   = !pause &&
                      (state == WASH || state == RINSE || state == SPIN);
  assign motor_fast = !pause && (state == SPIN);
  // A faulted drum that still holds water keeps the door latched.
  assign door_lock  = run || (state == ENDS && flt && !level_empty);
  assign busy       = run;
  assign done       = (state == ENDS) && !flt;
  assign fault      = flt;

endmodule

// File: doc/wm_cycle_ctrl.md
# wm_cycle_ctrl

Washing-machine cycle sequencer that drives the 3-bit stage code consumed by the 3-to-8 stage-lamp decoder. It steps through fill, wash, drain, rinse and spin, and drives the valve, pump, motor and door-lock actuators from water-level and door sensors. Stage durations are counted in prescaled timebase ticks. Fill and drain have timeouts that force a fault.

## Interface
- TICK_DIV, 1000: clock cycles per timebase tick.
- WASH_T, 12: wash duration, ticks.
- RINSE_T, 6: rinse duration, ticks.
- SPIN_T, 8: spin duration, ticks.
- FILL_TMO, 20: fill timeout, ticks.
- DRAIN_TMO, 20: drain timeout, ticks.
- clk  in  1  system clock.
- reset  in  1  reset, synchronous, active-high.
- start  in  1  start request, sampled each clock.
- pause  in  1  level; freezes the running stage.
- door_closed  in  1  door sensor.
- level_full  in  1  drum-full sensor.
- level_empty  in  1  drum-empty sensor.
- stage  out  3  stage code to the lamp decoder.
- valve_in  out  1  inlet valve.
- pump_out  out  1  drain pump.
- motor_on  out  1  drum motor.
- motor_fast  out  1  spin speed select.
- door_lock  out  1  door latch.
- busy  out  1  cycle running.
- done  out  1  cycle complete.
- fault  out  1  fault latched.

## Operation
- Stage codes:
  - 000 IDLE
  - 001 FILL1
  - 010 WASH
  - 011 DRAIN
  - 100 FILL2
  - 101 RINSE
  - 110 SPIN
  - 111 END
- END with fault=0 is DONE; END with fault=1 is FAULT.
- IDLE/DONE to FILL1: start=1 and door_closed=1. Otherwise start is ignored, including in every running stage and in FAULT.
- FILL1 to WASH and FILL2 to RINSE: level_full=1.
- WASH to DRAIN: after WASH_T ticks.
- DRAIN to FILL2: level_empty=1 (first pass).
- RINSE to SPIN: after RINSE_T ticks.
- SPIN to DONE: after SPIN_T ticks.
- Fill timeout: FILL_TMO ticks elapse without level_full, go to FAULT.
- Drain timeout: DRAIN_TMO ticks elapse without level_empty, go to FAULT.
- Any running stage with door_closed=0 goes to FAULT.
- Sensor and timer transitions are evaluated only while pause=0.
- Actuator outputs are Moore decodes of the state register, gated by pause. pause=1 forces valve_in, pump_out, motor_on and motor_fast to 0.
  - FILL1/FILL2: valve_in=1.
  - WASH/RINSE: motor_on=1.
  - DRAIN: pump_out=1.
  - SPIN: pump_out=1, motor_on=1, motor_fast=1.
- door_lock=1 in all stages 001–110. In FAULT it equals ~level_empty. Elsewhere 0.
- busy=1 in stages 001–110.
- FAULT exits only via reset.

## Timing
- Reset: stage=000. All outputs 0. Prescaler, tick timer and pass counter cleared.
- Prescaler counts 0..TICK_DIV-1 and emits a one-cycle tick at TICK_DIV-1.
- The stage timer and prescaler are cleared on every state entry.
- The prescaler and timer hold while pause=1.
- An unpaused timed stage lasts exactly T·TICK_DIV clocks. Its exit edge is the tick where timer==T-1.
- Transition latency: a condition sampled at edge n changes state at edge n. Outputs reflect the new state after edge n.
- Simultaneous events on one edge, highest priority first:
  1. reset
  2. door_closed=0
  3. level sensor satisfied
  4. timeout
- start and pause together in IDLE: start is accepted.

## Configuration
- WM_EXTRA_RINSE_EN defined: a 1-bit pass counter is cleared on FILL1 entry.
  - The first RINSE exits to DRAIN, with stage code 011 reused, instead of SPIN.
  - The second DRAIN, on level_empty, goes to FILL2.
  - The second RINSE goes to SPIN.
- Undefined: a single rinse, and the pass counter is absent.

## Test plan
Settings for all scenarios: TICK_DIV=4, WASH_T=3, RINSE_T=2, SPIN_T=2, FILL_TMO=5, DRAIN_TMO=5.
- Normal cycle:
  - Stimulus: start with door closed; level_full 3 clocks into each fill; level_empty 2 clocks into drain.
  - Required: stage sequence 001,010,011,100,101,110,111. WASH lasts 12 clocks, RINSE 8, SPIN 8. done=1, door_lock=0 at end.
- Door open at start:
  - Stimulus: start with door_closed=0.
  - Required: stage stays 000, busy=0.
- Fill timeout:
  - Stimulus: level_full never asserts.
  - Required: after 20 clocks in FILL1, stage=111, fault=1, valve_in=0, door_lock=1 until level_empty=1. A subsequent start is ignored.
- Pause in wash:
  - Stimulus: pause high 7 clocks mid-WASH.
  - Required: motor_on=0 during the pause; WASH lasts 19 clocks.
- Door open mid-cycle:
  - Stimulus: door_closed drops during RINSE.
  - Required: FAULT on the same edge.
  - Stimulus: door_closed drops on the edge level_full rises in FILL2.
  - Required: FAULT.
- Reset mid-SPIN:
  - Stimulus: reset during SPIN.
  - Required: next clock stage=000, all outputs 0. With WM_EXTRA_RINSE_EN, the normal cycle shows 101,011,100,101 before 110.
